// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a bounded
// memory-ready wait and sticky illegal/bus-error trap flags.
module multicycle_control_unit #(
  parameter int MAX_WAIT  = 15,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [2:0]           mem_size,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 ALUSrc,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic                 MemToReg,
  output logic                 RegWrite,
  output logic                 instr_done,
  output logic                 illegal,
  output logic                 bus_error
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [1:0] {C_RTYPE, C_IALU, C_LOAD, C_STORE} cls_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9;

  state_t     state, next;
  cls_t       cls, dec_cls;
  logic [3:0] op, dec_op, base_op;
  logic [2:0] funct3;
  logic [7:0] wait_cnt;
  logic       illegal_q, bus_error_q;
  logic       dec_legal, set_illegal, set_bus_error;
  logic       mem_phase, timeout;

  logic [2:0] f3;
  logic [6:0] opc;
  logic       i30;
  logic       unused_bits;
  assign f3  = instruction[14:12];
  assign opc = instruction[6:0];
  assign i30 = instruction[30];
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  always_comb begin
    base_op = OP_ADD;
    case (f3)
      3'b000: base_op = i30 ? OP_SUB : OP_ADD;
      3'b001: base_op = OP_SLL;
      3'b010: base_op = OP_SLT;
      3'b011: base_op = OP_SLTU;
      3'b100: base_op = OP_XOR;
      3'b101: base_op = i30 ? OP_SRA : OP_SRL;
      3'b110: base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_cls   = C_RTYPE;
    dec_op    = OP_ADD;
    case (opc)
      7'b0110011: begin
        dec_cls   = C_RTYPE;
        dec_op    = base_op;
        dec_legal = !i30 || f3 == 3'b000 || f3 == 3'b101;
      end
      7'b0010011: begin
        // addi has no SUB form: bit 30 is just immediate there
        dec_cls   = C_IALU;
        dec_op    = (f3 == 3'b000) ? OP_ADD : base_op;
        dec_legal = !(f3 == 3'b001 && i30);
      end
      7'b0000011: begin
        dec_cls   = C_LOAD;
        dec_legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      7'b0100011: begin
        dec_cls   = C_STORE;
        dec_legal = f3 inside {3'b000, 3'b001, 3'b010};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  assign timeout   = mem_phase && !mem_ready && (wait_cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    next          = state;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_size = 3'b000;
    IRWrite = 1'b0; PCWrite = 1'b0; ALUSrc = 1'b0; ALUCtrl = '0;
    MemToReg = 1'b0; RegWrite = 1'b0; instr_done = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            next    = S_DECODE;
          end else if (timeout) begin
            set_bus_error = 1'b1;
            next          = S_TRAP;
          end
        end
        S_DECODE: begin
          if (dec_legal) next = S_EXEC;
          else begin
            set_illegal = 1'b1;
            next        = S_TRAP;
          end
        end
        S_EXEC: begin
          ALUSrc  = (cls != C_RTYPE);
          ALUCtrl = ALUCTRL_W'(op);
          next    = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
        end
        S_MEM: begin
          IorD     = 1'b1;
          mem_size = funct3;
          ALUSrc   = 1'b1;
          MemRead  = (cls == C_LOAD);
          MemWrite = (cls == C_STORE);
          if (mem_ready) begin
            instr_done = (cls == C_STORE);
            next       = (cls == C_LOAD) ? S_WB : S_FETCH;
          end else if (timeout) begin
            set_bus_error = 1'b1;
            next          = S_TRAP;
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          MemToReg   = (cls == C_LOAD);
          instr_done = 1'b1;
          next       = S_FETCH;
        end
        default: next = S_TRAP;
      endcase
    end
  end

  assign illegal   = illegal_q & ~rst;
  assign bus_error = bus_error_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      cls         <= C_RTYPE;
      op          <= OP_ADD;
      funct3      <= 3'b000;
      wait_cnt    <= 8'd0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state       <= next;
      illegal_q   <= illegal_q | set_illegal;
      bus_error_q <= bus_error_q | set_bus_error;
      if (state == S_DECODE) begin
        cls    <= dec_cls;
        op     <= dec_op;
        funct3 <= f3;
      end
      // counts only uninterrupted waiting within one memory state
      if (mem_phase && !mem_ready && next == state) wait_cnt <= wait_cnt + 8'd1;
      else wait_cnt <= 8'd0;
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control sequencer for the RV32I datapath. It replaces the single-cycle decoder: it steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It waits on a memory ready handshake, with a bounded timeout. It emits per-state datapath strobes plus a decoded ALU operation, and sits between the shared instruction/data memory port, the IR/PC registers, the register file and the ALU.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive cycles a memory request may wait for mem_ready; legal range 1..255.
- ALUCTRL_W, 4: width of ALUCtrl; must be >= 4.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- instruction  in  32  IR contents; stable from the DECODE cycle until the next IRWrite.
- mem_ready  in  1  memory has completed the current request this cycle.
- IorD  out  1  memory address select: 0 = PC (fetch), 1 = ALU result (data).
- MemRead  out  1  memory read request, held until accepted.
- MemWrite  out  1  memory write request, held until accepted.
- mem_size  out  3  funct3 of the current load/store; 0 during fetch.
- IRWrite  out  1  latch fetched word into IR.
- PCWrite  out  1  PC <= PC+4.
- ALUSrc  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- ALUCtrl  out  ALUCTRL_W  ALU operation; encoding below, zero-extended.
- MemToReg  out  1  write-back source: 1 = memory data, 0 = ALU result.
- RegWrite  out  1  register-file write enable.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  sticky: an unsupported instruction was decoded.
- bus_error  out  1  sticky: a memory request timed out.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- ALUCtrl encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- **FETCH:** IorD=0, MemRead=1.
  - On mem_ready: IRWrite=1 and PCWrite=1 in that same cycle (Mealy); next state DECODE.
- **DECODE:** classify {instruction[30], instruction[14:12], instruction[6:0]} and register the class and ALUCtrl.
  - R-type (0110011): all 8 funct3 codes. instruction[30] selects SUB/SRA, and is legal only with funct3 000 or 101.
  - I-ALU (0010011): all funct3 codes.
    - addi never yields SUB.
    - slli requires instruction[30]=0.
    - srli/srai are selected by instruction[30].
  - Load (0000011): funct3 000, 001, 010, 100 or 101.
  - Store (0100011): funct3 000, 001 or 010.
  - Anything else -> TRAP with illegal=1. Otherwise -> EXEC.
- **EXEC:** ALUSrc=0 for R-type, 1 otherwise. ALUCtrl = decoded op (ADD for load/store).
  - R-type and I-ALU -> WB; load and store -> MEM.
- **MEM:** IorD=1, mem_size=funct3, ALUSrc=1, ALUCtrl=ADD.
  - MemRead=1 for a load, MemWrite=1 for a store.
  - On mem_ready: load -> WB; store -> FETCH with instr_done=1.
- **WB:** RegWrite=1 and MemToReg = (class==load); instr_done=1; next state FETCH.
- **TRAP:** all strobes 0 and sticky flags held; the block stays in TRAP until rst.
- **Wait counter:** counts the cycles in FETCH/MEM with mem_ready=0, and clears on mem_ready or on any state change.
  - When it reaches MAX_WAIT with mem_ready still 0 -> TRAP with bus_error=1.
  - mem_ready in the same cycle as the limit wins: no error is raised.
- A strobe not listed for a state is 0 in that state.

## Timing
- While rst=1 every output is 0. On the first edge with rst=1 the state goes to FETCH and the counter and sticky flags clear.
- In the first cycle after rst falls, MemRead=1 and IorD=0.
- With zero-wait memory:
  - R/I-ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles (FETCH, DECODE, EXEC, MEM).
- Each wait cycle adds 1 cycle of latency. MemRead/MemWrite, IorD and mem_size stay constant while waiting.
- rst asserted mid-instruction takes priority over everything else:
  - It aborts the memory request and returns to FETCH.
  - No RegWrite or instr_done is issued in the cycle rst is high.
- mem_ready outside FETCH/MEM is ignored.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready tied 1:
  - IRWrite+PCWrite in cycle 0, ALUCtrl=0 with ALUSrc=0 in cycle 2, RegWrite+instr_done in cycle 3.
- lw x5,8(x1) (0x0080A283), mem_ready delayed 3 cycles in MEM:
  - MemRead/IorD=1/mem_size=2 held for 4 cycles; then WB with MemToReg=1, RegWrite=1.
- sw x5,4(x1) (0x0050A223):
  - MemWrite=1 in MEM, instr_done on acceptance, RegWrite never asserted.
- srai x4,x4,3 (0x40325213) -> ALUCtrl=7 with ALUSrc=1; sub (0x402081B3) -> ALUCtrl=1.
- Illegal word 0x0000707F -> TRAP after DECODE with illegal=1 and no strobes. rst then clears it, and FETCH restarts.
- mem_ready held 0 in FETCH with MAX_WAIT=15 -> bus_error=1 after 15 wait cycles.
  - Repeat with mem_ready arriving in exactly the 15th cycle -> no error, normal completion.
